// File: rtl/axis_pkt_arbiter_512.sv
// axis_pkt_arbiter_512
// Packet-granular round-robin arbiter: NUM_SRC AXI-Stream slaves share one
// registered AXI-Stream master. A grant is held from the first beat until the
// TLAST handshake, so packets never interleave. One IDLE (arbitration) cycle
// separates packets.
//
// Optional feature: define AXIS_ARB_TID_EN to add M_AXIS_TID, the source index
// of each output beat, registered alongside M_AXIS_TDATA.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; pick next valid source after last_grant (wrapping)
// XFER  | grant_id locked; forward beats until the TLAST handshake
module axis_pkt_arbiter_512 #(
  parameter int  NUM_SRC            = 4,
  parameter int  C_AXIS_TDATA_WIDTH = 512,
  localparam int IDX_W              = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC-1:0]                    S_AXIS_TVALID,
  input  logic [NUM_SRC-1:0]                    S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]                    S_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic                                  M_AXIS_TVALID,
  output logic                                  M_AXIS_TLAST,
`ifdef AXIS_ARB_TID_EN
  output logic [IDX_W-1:0]                      M_AXIS_TID,
`endif
  input  logic                                  M_AXIS_TREADY,
  output logic [IDX_W-1:0]                      grant_id,
  output logic                                  busy
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                        state;
  logic [IDX_W-1:0]              last_grant;
  logic [IDX_W-1:0]              next_idx;
  logic [IDX_W-1:0]              cand;
  logic                          found;
  logic                          out_free;
  logic                          s_hs;
  logic                          s_last;
  logic [C_AXIS_TDATA_WIDTH-1:0] src_data [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slice
    assign src_data[g] = S_AXIS_TDATA[g*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
  end

  // Round-robin search: first valid source strictly after last_grant, with wrap.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_SRC);
      if (!found && S_AXIS_TVALID[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle;
  // ready deliberately ignores the slave's TVALID.
  assign out_free = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign s_hs     = (state == XFER) && out_free && S_AXIS_TVALID[grant_id];
  assign s_last   = S_AXIS_TLAST[grant_id];

  // Only the granted source sees ready, and only while in XFER.
  always_comb begin
    S_AXIS_TREADY = '0;
    if (state == XFER) S_AXIS_TREADY[grant_id] = out_free;
  end

  // Grant FSM plus the one-entry output stage.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      grant_id      <= '0;
      last_grant    <= IDX_W'(NUM_SRC - 1);
      busy          <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
`ifdef AXIS_ARB_TID_EN
      M_AXIS_TID    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= next_idx;
            state    <= XFER;
            busy     <= 1'b1;
          end
        end
        XFER: begin
          // A stalled granted source keeps the grant indefinitely.
          if (s_hs && s_last) begin
            last_grant <= grant_id;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (s_hs) begin
        M_AXIS_TDATA  <= src_data[grant_id];
        M_AXIS_TLAST  <= s_last;
        M_AXIS_TVALID <= 1'b1;
`ifdef AXIS_ARB_TID_EN
        M_AXIS_TID    <= grant_id;
`endif
      end else if (M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter_512.sv
// Testbench for axis_pkt_arbiter_512: directed scenarios plus a randomized
// run, all checked against a packet-level round-robin reference model.
module tb_axis_pkt_arbiter_512;
  localparam int NUM   = 4;
  localparam int W     = 512;
  localparam int IDX_W = 2;

  typedef logic [511:0] v_t;
  typedef struct packed {logic [W-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [W-1:0] data; logic last; logic [IDX_W-1:0] src;} obeat_t;

  logic             aclk = 1'b0;
  logic             areset;
  logic [NUM*W-1:0] s_tdata;
  logic [NUM-1:0]   s_tvalid, s_tlast, s_tready;
  logic [W-1:0]     m_tdata;
  logic             m_tvalid, m_tlast, m_tready;
  logic [IDX_W-1:0] grant_id;
  logic             busy;
`ifdef AXIS_ARB_TID_EN
  logic [IDX_W-1:0] m_tid;
`endif

  always #5 aclk = ~aclk;

  axis_pkt_arbiter_512 #(.NUM_SRC(NUM), .C_AXIS_TDATA_WIDTH(W)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TLAST  (m_tlast),
`ifdef AXIS_ARB_TID_EN
    .M_AXIS_TID    (m_tid),
`endif
    .M_AXIS_TREADY (m_tready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  // Reference model state
  beat_t        src_q [NUM][$];
  obeat_t       exp_q [$];
  int           grant_log [$];
  int           mdl_last, mdl_grant;
  bit           mdl_xfer;
  bit           prev_mv, prev_mr, prev_ml, prev_acc;
  logic [W-1:0] prev_md;
  int           acc_cnt [NUM];
  int           vpct [NUM];
  int           rpct;
  int           n_checks, n_fail;

  task automatic chk_val(input string tag, input v_t got, input v_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM; i++) begin
      src_q[i].delete();
      acc_cnt[i] = 0;
    end
    exp_q.delete();
    grant_log.delete();
    mdl_last  = NUM - 1;
    mdl_grant = 0;
    mdl_xfer  = 0;
    prev_mv   = 0;
    prev_mr   = 0;
    prev_ml   = 0;
    prev_acc  = 0;
    prev_md   = '0;
  endtask

  task automatic add_beat(input int s, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[s].push_back(b);
  endtask

  task automatic add_pkt(input int s, input int len);
    for (int k = 0; k < len; k++) add_beat(s, {16{$urandom()}}, (k == len - 1));
  endtask

  // Sources present their queue head with probability vpct; idle sources
  // drive garbage so non-granted data is free to wander.
  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      if (src_q[i].size() > 0 && $urandom_range(99) < vpct[i]) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*W +: W]    = src_q[i][0].data;
        s_tlast[i]           = src_q[i][0].last;
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*W +: W]    = {16{$urandom()}};
        s_tlast[i]           = 1'($urandom_range(1));
      end
    end
    m_tready = ($urandom_range(99) < rpct);
  endtask

  // Called on the falling edge: checks this cycle, then predicts the next.
  task automatic monitor();
    obeat_t         e;
    beat_t          b;
    logic [NUM-1:0] er;
    bit             last_hs;
    int             w, s;

    chk_val("busy", v_t'(busy), v_t'(mdl_xfer));
    chk_val("grant_id", v_t'(grant_id), v_t'(mdl_grant));
    er = '0;
    if (mdl_xfer && (!m_tvalid || m_tready)) er[mdl_grant] = 1'b1;
    chk_val("s_tready", v_t'(s_tready), v_t'(er));

    if (prev_acc) chk_val("out_latency", v_t'(m_tvalid), v_t'(1));
    if (prev_mv && !prev_mr) begin
      chk_val("hold_valid", v_t'(m_tvalid), v_t'(1));
      chk_val("hold_data", v_t'(m_tdata), v_t'(prev_md));
      chk_val("hold_last", v_t'(m_tlast), v_t'(prev_ml));
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk_val("out_extra_beat", v_t'(1), v_t'(0));
      end else begin
        e = exp_q.pop_front();
        chk_val("out_data", v_t'(m_tdata), v_t'(e.data));
        chk_val("out_last", v_t'(m_tlast), v_t'(e.last));
`ifdef AXIS_ARB_TID_EN
        chk_val("out_tid", v_t'(m_tid), v_t'(e.src));
`endif
      end
    end

    last_hs  = 0;
    prev_acc = 0;
    for (int i = 0; i < NUM; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        chk_val("hs_src", v_t'(i), v_t'(mdl_grant));
        b      = src_q[i].pop_front();
        e.data = b.data;
        e.last = b.last;
        e.src  = IDX_W'(i);
        exp_q.push_back(e);
        acc_cnt[i]++;
        prev_acc = 1;
        if (b.last) last_hs = 1;
      end
    end

    if (mdl_xfer) begin
      if (last_hs) begin
        mdl_last = mdl_grant;
        mdl_xfer = 0;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= NUM; k++) begin
        s = (mdl_last + k) % NUM;
        if (w < 0 && s_tvalid[s]) w = s;
      end
      if (w >= 0) begin
        mdl_grant = w;
        mdl_xfer  = 1;
        grant_log.push_back(w);
      end
    end

    prev_mv = m_tvalid;
    prev_mr = m_tready;
    prev_md = m_tdata;
    prev_ml = m_tlast;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    drive();
    @(negedge aclk);
    monitor();
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    areset   = 1'b1;
    s_tvalid = '0;
    m_tready = 1'b0;
    reset_model();
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() > 0) || mdl_xfer;
    for (int i = 0; i < NUM; i++) if (src_q[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    chk_val("drain_timeout", v_t'(pending()), v_t'(0));
  endtask

  task automatic run_until_acc(input int s, input int cnt, input int budget);
    int n;
    n = 0;
    while (acc_cnt[s] < cnt && n < budget) begin
      step();
      n++;
    end
    chk_val("acc_timeout", v_t'(acc_cnt[s] >= cnt), v_t'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] da, db, dc;
    int           ord2 [5];
    n_checks = 0;
    n_fail   = 0;
    areset   = 1'b1;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    rpct     = 100;
    for (int i = 0; i < NUM; i++) vpct[i] = 100;
    reset_model();

    #12;
    chk_val("rst_m_tvalid", v_t'(m_tvalid), v_t'(0));
    chk_val("rst_m_tdata", v_t'(m_tdata), v_t'(0));
    chk_val("rst_m_tlast", v_t'(m_tlast), v_t'(0));
    chk_val("rst_busy", v_t'(busy), v_t'(0));
    chk_val("rst_grant", v_t'(grant_id), v_t'(0));
    chk_val("rst_s_tready", v_t'(s_tready), v_t'(0));
`ifdef AXIS_ARB_TID_EN
    chk_val("rst_tid", v_t'(m_tid), v_t'(0));
`endif
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // 3-beat packet on source 2
    da = {128{4'hA}};
    db = {128{4'hB}};
    dc = {128{4'hC}};
    add_beat(2, da, 1'b0);
    add_beat(2, db, 1'b0);
    add_beat(2, dc, 1'b1);
    step();
    chk_val("t1_idle_rdy", v_t'(s_tready), v_t'(0));
    step();
    chk_val("t1_rdy0", v_t'(s_tready), v_t'(4'b0100));
    chk_val("t1_grant", v_t'(grant_id), v_t'(2));
    step();
    chk_val("t1_rdy1", v_t'(s_tready), v_t'(4'b0100));
    chk_val("t1_data_a", v_t'(m_tdata), v_t'(da));
    step();
    chk_val("t1_data_b", v_t'(m_tdata), v_t'(db));
    step();
    chk_val("t1_data_c", v_t'(m_tdata), v_t'(dc));
    chk_val("t1_last_c", v_t'(m_tlast), v_t'(1));
    chk_val("t1_grant_hold", v_t'(grant_id), v_t'(2));
    drain(20);

    // All sources busy with 2-beat packets: order 0,1,2,3,0
    do_reset();
    for (int s = 0; s < NUM; s++) add_pkt(s, 2);
    add_pkt(0, 2);
    drain(100);
    ord2 = '{0, 1, 2, 3, 0};
    chk_val("t2_npkts", v_t'(grant_log.size()), v_t'(5));
    if (grant_log.size() == 5)
      for (int k = 0; k < 5; k++) chk_val("t2_order", v_t'(grant_log[k]), v_t'(ord2[k]));

    // Downstream stall for 5 cycles mid-packet on source 1
    do_reset();
    add_pkt(1, 4);
    run_until_acc(1, 2, 20);
    rpct = 0;
    repeat (5) begin
      step();
      chk_val("t3_full", v_t'(m_tvalid), v_t'(1));
      chk_val("t3_rdy1", v_t'(s_tready[1]), v_t'(0));
    end
    rpct = 100;
    drain(50);

    // Granted source 0 stalls while source 3 waits
    do_reset();
    add_pkt(0, 4);
    add_pkt(3, 1);
    run_until_acc(0, 2, 20);
    vpct[0] = 0;
    repeat (4) begin
      step();
      chk_val("t4_grant_held", v_t'(grant_id), v_t'(0));
      chk_val("t4_rdy3", v_t'(s_tready[3]), v_t'(0));
    end
    vpct[0] = 100;
    drain(50);
    chk_val("t4_npkts", v_t'(grant_log.size()), v_t'(2));
    if (grant_log.size() == 2) chk_val("t4_second", v_t'(grant_log[1]), v_t'(3));

    // Reset mid-packet, then source 0 beats source 2
    do_reset();
    add_pkt(1, 4);
    run_until_acc(1, 2, 20);
    areset = 1'b1;
    #1;
    chk_val("t5_rst_mvalid", v_t'(m_tvalid), v_t'(0));
    chk_val("t5_rst_srdy", v_t'(s_tready), v_t'(0));
    chk_val("t5_rst_busy", v_t'(busy), v_t'(0));
    @(posedge aclk);
    #1;
    s_tvalid = '0;
    reset_model();
    areset = 1'b0;
    add_pkt(0, 2);
    add_pkt(2, 2);
    drain(50);
    chk_val("t5_npkts", v_t'(grant_log.size()), v_t'(2));
    if (grant_log.size() == 2) begin
      chk_val("t5_first", v_t'(grant_log[0]), v_t'(0));
      chk_val("t5_second", v_t'(grant_log[1]), v_t'(2));
    end

    // Alternating sources 1 and 3 (source index tagged on each beat)
    do_reset();
    add_pkt(1, 2);
    add_pkt(3, 2);
    add_pkt(1, 1);
    add_pkt(3, 3);
    drain(60);
    chk_val("t6_npkts", v_t'(grant_log.size()), v_t'(4));

    // Randomized traffic with random backpressure
    do_reset();
    for (int i = 0; i < NUM; i++) vpct[i] = int'($urandom_range(100, 30));
    rpct = 60;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM; i++)
        if (src_q[i].size() < 2 && $urandom_range(3) == 0) add_pkt(i, int'($urandom_range(5, 1)));
      step();
    end
    for (int i = 0; i < NUM; i++) vpct[i] = 100;
    rpct = 100;
    drain(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
